score_sequencer: RTL and testbench
==================================

// Module: score_sequencer
// PURPOSE
//  Parametrised tune player driving the buzzer/amplifier pins. Walks an external score ROM
//  one slot per tempo tick and maps each note code to a square wave via an internal pitch
//  table (low/middle/high octave, rest). Adds start/stop/pause control, loop/one-shot mode
//  and status. Sits between the game controller FSM and the board buzzer (beep, sd).
// PARAMETERS
//  TICK_CYCLES  15_555_555  clk cycles per score slot (fetch cycle included); must be >= 2
//  SONG_LEN     351         number of slots played, addresses 0..SONG_LEN-1; >= 1
//  ADDR_W       9           score address width; 2**ADDR_W >= SONG_LEN
//  NOTE_W       5           score code width
//  DIV_W        18          tone half-period counter width
//  TONE_SHIFT   0           half-period = table >> TONE_SHIFT (simulation speed-up)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       1-cycle request; begin at slot 0; ignored while busy
//  stop        in   1       abort playback, return to idle
//  pause       in   1       level; freezes playback while high
//  loop_en     in   1       level; sampled at end of last slot: 1 = restart at 0
//  score_addr  out  ADDR_W  score ROM address
//  score_code  in   NOTE_W  ROM data, valid 1 cycle after score_addr changes
//  note_code   out  NOTE_W  code currently sounding (0 when idle)
//  beep        out  1       buzzer square wave
//  sd          out  1       amplifier enable: 1 while busy
//  busy        out  1       1 in FETCH/PLAY/PAUSE
//  done        out  1       1-cycle pulse when one-shot playback completes
// BEHAVIOUR
//  Reset: state IDLE; score_addr, note_code, all counters = 0; beep, sd, busy, done = 0.
//  Pitch table, half-period in clk cycles: code 0 = rest; 1..7 = L1..L7 = 127552, 113636,
//   101236, 95548, 85136, 75838, 67567; 8..14 = M1..M7 = 63776, 56818, 50607, 47778, 42553,
//   37936, 33783; 15..21 = H1..H7 = M_n >> 1; codes 22..31 = rest.
//  FSM: IDLE -start-> FETCH (addr 0). FETCH (1 cycle): ROM read in flight. Next cycle:
//   latch score_code into note_code, clear tone counter, beep = 0, enter PLAY.
//   PLAY lasts TICK_CYCLES-1 cycles, so each slot is exactly TICK_CYCLES cycles.
//   End of slot: addr < SONG_LEN-1 -> addr+1, FETCH. Last slot with loop_en = 1 -> addr 0, FETCH.
//   Last slot with loop_en = 0 -> IDLE, done = 1 for 1 cycle, note_code = 0, beep = 0.
//  Tone: in PLAY with non-rest code, half_cnt counts 0..H-1 (H = table >> TONE_SHIFT).
//   At H-1: toggle beep, half_cnt = 0. Compare is >= so no wrap-around occurs.
//   Rest code, or H == 0: beep held 0, half_cnt held 0.
//  Pause: in FETCH/PLAY with pause = 1 -> PAUSE next cycle. Slot and tone counters frozen,
//   beep forced 0. Pause = 0 -> back to the saved state; remaining slot time is unchanged.
//  Stop: from any state -> IDLE next cycle. Same outputs as reset, except done stays 0.
//  Priority on the same cycle: stop > pause > slot advance. A start arriving with stop is ignored.
//  Slot counter width = clog2(TICK_CYCLES). Tone counter truncates H to DIV_W bits.
//  sd = busy, so the amplifier is off in IDLE. Outputs are registered.
// TESTING (TICK_CYCLES=20, SONG_LEN=4, TONE_SHIFT=12, ROM = {8,0,5,15})
//  Reset mid-note (rst_n low 1 cycle) -> beep=0, busy=0, score_addr=0 immediately.
//  start, loop_en=0 -> busy 80 cycles. Slot0 beep toggles every 15 cycles (63776>>12).
//   Slot1 beep=0. Slot2 toggles every 20 cycles. Slot3 every 7 cycles. Then done 1-cycle pulse.
//  start, loop_en=1 -> score_addr sequence 0,1,2,3,0,1 at 20-cycle spacing; done never asserts.
//  pause held 50 cycles at cycle 5 of slot0 -> beep 0 during pause; slot0 then ends 15 cycles
//   after release.
//  stop at cycle 10 of slot2 -> IDLE next cycle, sd=0, done=0. start 1 cycle later replays from addr 0.
//  start while busy -> ignored; score_addr sequence unchanged.

Source files
------------

// File: rtl/score_sequencer.sv
// Tune player: walks an external score ROM one slot per tempo tick and turns each
// note code into a square wave on beep, with start/stop/pause and loop/one-shot control.
module score_sequencer #(
    parameter int unsigned TICK_CYCLES = 15_555_555,
    parameter int unsigned SONG_LEN    = 351,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned NOTE_W      = 5,
    parameter int unsigned DIV_W       = 18,
    parameter int unsigned TONE_SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] score_addr,
    input  logic [NOTE_W-1:0] score_code,
    output logic [NOTE_W-1:0] note_code,
    output logic              beep,
    output logic              sd,
    output logic              busy,
    output logic              done
);
    localparam int unsigned SLOT_W = $clog2(TICK_CYCLES);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, PAUSE} state_t;

    state_t             state_q;
    state_t             resume_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [NOTE_W-1:0]  note_q;
    logic [SLOT_W-1:0]  slot_cnt_q;
    logic [DIV_W-1:0]   half_cnt_q;
    logic               beep_q;
    logic               busy_q;
    logic               done_q;

    logic [DIV_W-1:0]   tone_h;
    logic               slot_end;
    logic               last_slot;
    logic               tone_hit;

    // Half-period in clk cycles; H octave is the middle octave halved, unused codes rest.
    function automatic logic [31:0] pitch_of(input logic [NOTE_W-1:0] code);
        logic [31:0] p;
        case (32'(code))
            32'd1:  p = 32'd127552;
            32'd2:  p = 32'd113636;
            32'd3:  p = 32'd101236;
            32'd4:  p = 32'd95548;
            32'd5:  p = 32'd85136;
            32'd6:  p = 32'd75838;
            32'd7:  p = 32'd67567;
            32'd8:  p = 32'd63776;
            32'd9:  p = 32'd56818;
            32'd10: p = 32'd50607;
            32'd11: p = 32'd47778;
            32'd12: p = 32'd42553;
            32'd13: p = 32'd37936;
            32'd14: p = 32'd33783;
            32'd15: p = 32'd63776 >> 1;
            32'd16: p = 32'd56818 >> 1;
            32'd17: p = 32'd50607 >> 1;
            32'd18: p = 32'd47778 >> 1;
            32'd19: p = 32'd42553 >> 1;
            32'd20: p = 32'd37936 >> 1;
            32'd21: p = 32'd33783 >> 1;
            default: p = 32'd0;
        endcase
        return p;
    endfunction

    assign tone_h    = DIV_W'(pitch_of(note_q) >> TONE_SHIFT);
    assign tone_hit  = (half_cnt_q >= tone_h - DIV_W'(1));
    assign slot_end  = (slot_cnt_q == SLOT_W'(TICK_CYCLES - 2));
    assign last_slot = (addr_q == ADDR_W'(SONG_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            resume_q   <= IDLE;
            addr_q     <= '0;
            note_q     <= '0;
            slot_cnt_q <= '0;
            half_cnt_q <= '0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q    <= IDLE;
                addr_q     <= '0;
                note_q     <= '0;
                slot_cnt_q <= '0;
                half_cnt_q <= '0;
                beep_q     <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= FETCH;
                            addr_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (pause) begin
                            resume_q <= FETCH;
                            state_q  <= PAUSE;
                            beep_q   <= 1'b0;
                        end else begin
                            note_q     <= score_code;
                            half_cnt_q <= '0;
                            slot_cnt_q <= '0;
                            beep_q     <= 1'b0;
                            state_q    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (pause) begin
                            resume_q <= PLAY;
                            state_q  <= PAUSE;
                            beep_q   <= 1'b0;
                        end else begin
                            if (tone_h == '0) begin
                                beep_q     <= 1'b0;
                                half_cnt_q <= '0;
                            end else if (tone_hit) begin
                                beep_q     <= ~beep_q;
                                half_cnt_q <= '0;
                            end else begin
                                half_cnt_q <= half_cnt_q + DIV_W'(1);
                            end
                            if (slot_end) begin
                                slot_cnt_q <= '0;
                                if (!last_slot) begin
                                    addr_q  <= addr_q + ADDR_W'(1);
                                    state_q <= FETCH;
                                end else if (loop_en) begin
                                    addr_q  <= '0;
                                    state_q <= FETCH;
                                end else begin
                                    // One-shot finished: silence everything and report once.
                                    state_q    <= IDLE;
                                    addr_q     <= '0;
                                    note_q     <= '0;
                                    half_cnt_q <= '0;
                                    beep_q     <= 1'b0;
                                    busy_q     <= 1'b0;
                                    done_q     <= 1'b1;
                                end
                            end else begin
                                slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause) begin
                            state_q <= resume_q;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign score_addr = addr_q;
    assign note_code  = note_q;
    assign beep       = beep_q;
    assign sd         = busy_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: vector table, directed corner sequences and random
// control traffic, all checked every cycle against a slot/elapsed-time reference model.
module tb_score_sequencer;
    localparam int T     = 20;
    localparam int LEN   = 4;
    localparam int SHIFT = 12;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic       loop_en;
    logic [8:0] score_addr;
    logic [4:0] score_code;
    logic [4:0] note_code;
    logic       beep;
    logic       sd;
    logic       busy;
    logic       done;

    int rom [4]    = '{8, 0, 5, 15};
    int lo_tbl [7] = '{127552, 113636, 101236, 95548, 85136, 75838, 67567};
    int mi_tbl [7] = '{63776, 56818, 50607, 47778, 42553, 37936, 33783};

    int errors = 0;
    int checks = 0;

    score_sequencer #(
        .TICK_CYCLES(T), .SONG_LEN(LEN), .ADDR_W(9), .NOTE_W(5), .DIV_W(18), .TONE_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .score_addr(score_addr), .score_code(score_code),
        .note_code(note_code), .beep(beep), .sd(sd), .busy(busy), .done(done)
    );

    assign score_code = 5'(rom[score_addr[1:0]]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which slot, how many cycles of it have elapsed (0 = still fetching),
    // and how many tone-counting cycles have run; beep follows from division.
    bit m_run, m_paused, m_beep, m_done;
    int m_slot, m_elapsed, m_n, m_base, m_note;

    function automatic int half_of(input int code);
        if (code >= 1 && code <= 7)   return lo_tbl[code-1] >> SHIFT;
        if (code >= 8 && code <= 14)  return mi_tbl[code-8] >> SHIFT;
        if (code >= 15 && code <= 21) return (mi_tbl[code-15] >> 1) >> SHIFT;
        return 0;
    endfunction

    task automatic model_idle();
        m_run = 0; m_paused = 0; m_beep = 0; m_slot = 0;
        m_elapsed = 0; m_n = 0; m_base = 0; m_note = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit pa, input bit lp);
        int h;
        m_done = 0;
        h = half_of(m_note);
        if (sp) begin
            model_idle();
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_paused = 0; m_slot = 0; m_elapsed = 0;
            end
        end else if (m_paused) begin
            if (!pa) m_paused = 0;
        end else if (pa) begin
            m_paused = 1;
            m_beep   = 0;
            m_base   = (h > 0) ? m_n / h : 0;
        end else if (m_elapsed == 0) begin
            m_note = rom[m_slot]; m_elapsed = 1; m_n = 0; m_base = 0; m_beep = 0;
        end else begin
            m_n++;
            m_elapsed++;
            m_beep = (h > 0) ? (((m_n / h - m_base) % 2) != 0) : 0;
            if (m_elapsed == T) begin
                if (m_slot < LEN - 1) begin
                    m_slot++; m_elapsed = 0;
                end else if (lp) begin
                    m_slot = 0; m_elapsed = 0;
                end else begin
                    model_idle();
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic check_cycle(input string name);
        int e_addr;
        e_addr = m_run ? m_slot : 0;
        checks++;
        if (int'(score_addr) != e_addr || int'(note_code) != m_note || beep !== m_beep ||
            sd !== m_run || busy !== m_run || done !== m_done) begin
            errors++;
            $display("FAIL %s t=%0t got addr=%0d note=%0d beep=%b sd=%b busy=%b done=%b want addr=%0d note=%0d beep=%b sd=%b busy=%b done=%b",
                     name, $time, score_addr, note_code, beep, sd, busy, done,
                     e_addr, m_note, m_beep, m_run, m_run, m_done);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        model_step(start, stop, pause, loop_en);
        #1;
        check_cycle(name);
    endtask

    task automatic run(input int n, input string name);
        for (int k = 0; k < n; k++) tick(name);
    endtask

    typedef struct {
        int st, sp, pa, lp, cyc;
        int addr, bsy, dn, bp, note;
    } vec_t;
    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1,0,0,0, 1, 0,1,0,0,0};
        vecs[1]  = '{0,0,0,0, 1, 0,1,0,0,8};
        vecs[2]  = '{0,0,0,0,14, 0,1,0,0,8};
        vecs[3]  = '{0,0,0,0, 1, 0,1,0,1,8};
        vecs[4]  = '{0,0,0,0, 4, 1,1,0,1,8};
        vecs[5]  = '{0,0,0,0, 1, 1,1,0,0,0};
        vecs[6]  = '{0,0,0,0,19, 2,1,0,0,0};
        vecs[7]  = '{0,0,0,0, 1, 2,1,0,0,5};
        vecs[8]  = '{0,0,0,0,19, 3,1,0,0,5};
        vecs[9]  = '{0,0,0,0, 1, 3,1,0,0,15};
        vecs[10] = '{0,0,0,0, 7, 3,1,0,1,15};
        vecs[11] = '{0,0,0,0, 7, 3,1,0,0,15};
        vecs[12] = '{0,0,0,0, 5, 0,0,1,0,0};
        vecs[13] = '{0,0,0,0, 1, 0,0,0,0,0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        model_idle();
        m_done = 0;
        repeat (2) @(posedge clk);
        #1;
        check_cycle("reset");
        rst_n = 1'b1;

        // One-shot playback through the whole song.
        for (int i = 0; i < 14; i++) begin
            start = (vecs[i].st != 0); stop = (vecs[i].sp != 0);
            pause = (vecs[i].pa != 0); loop_en = (vecs[i].lp != 0);
            run(vecs[i].cyc, "table_cycle");
            checks++;
            if (int'(score_addr) != vecs[i].addr || int'(busy) != vecs[i].bsy ||
                int'(done) != vecs[i].dn || int'(beep) != vecs[i].bp ||
                int'(note_code) != vecs[i].note) begin
                errors++;
                $display("FAIL vec%0d got addr=%0d busy=%b done=%b beep=%b note=%0d want addr=%0d busy=%0d done=%0d beep=%0d note=%0d",
                         i, score_addr, busy, done, beep, note_code,
                         vecs[i].addr, vecs[i].bsy, vecs[i].dn, vecs[i].bp, vecs[i].note);
            end
            $display("vec %0d: addr=%0d busy=%b done=%b beep=%b note=%0d",
                     i, score_addr, busy, done, beep, note_code);
        end
        start = 1'b0;

        // Asynchronous reset in the middle of a sounding note.
        start = 1'b1; tick("rst_start"); start = 1'b0;
        run(16, "rst_play");
        chk("rst_pre_beep", int'(beep), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_beep", int'(beep), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_addr", int'(score_addr), 0);
        @(posedge clk);
        #1;
        model_idle();
        m_done = 0;
        check_cycle("rst_held");
        rst_n = 1'b1;
        $display("txn async reset: addr=%0d busy=%b beep=%b", score_addr, busy, beep);

        // Looping playback wraps back to slot 0 and never reports done.
        loop_en = 1'b1;
        start = 1'b1; tick("loop_start"); start = 1'b0;
        chk("loop_addr0", int'(score_addr), 0);
        for (int k = 1; k <= 5; k++) begin
            run(T, "loop_run");
            chk("loop_addr", int'(score_addr), k % LEN);
            $display("txn loop slot %0d: addr=%0d", k, score_addr);
        end
        stop = 1'b1; tick("loop_stop"); stop = 1'b0;
        chk("loop_stop_busy", int'(busy), 0);
        loop_en = 1'b0;

        // Pause held 50 cycles starting at cycle 5 of slot 0.
        start = 1'b1; tick("pause_start"); start = 1'b0;
        run(5, "pause_pre");
        pause = 1'b1;
        run(25, "pause_hold");
        chk("pause_beep", int'(beep), 0);
        chk("pause_busy", int'(busy), 1);
        run(25, "pause_hold");
        pause = 1'b0;
        run(15, "pause_resume");
        chk("pause_addr_before", int'(score_addr), 0);
        tick("pause_edge");
        chk("pause_addr_after", int'(score_addr), 1);
        $display("txn pause: slot0 ended, addr=%0d", score_addr);
        stop = 1'b1; tick("pause_stop"); stop = 1'b0;

        // Stop at cycle 10 of slot 2, restart, and an ignored start while busy.
        start = 1'b1; tick("stop_start"); start = 1'b0;
        run(50, "stop_run");
        chk("stop_pre_addr", int'(score_addr), 2);
        stop = 1'b1; tick("stop_hit"); stop = 1'b0;
        chk("stop_sd", int'(sd), 0);
        chk("stop_done", int'(done), 0);
        chk("stop_addr", int'(score_addr), 0);
        start = 1'b1; tick("restart"); start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        run(9, "restart_run");
        start = 1'b1; tick("busy_start"); start = 1'b0;
        run(9, "restart_run");
        chk("busy_start_addr0", int'(score_addr), 0);
        tick("restart_edge");
        chk("busy_start_addr1", int'(score_addr), 1);
        $display("txn stop/restart: addr=%0d busy=%b", score_addr, busy);
        stop = 1'b1; tick("restart_stop"); stop = 1'b0;

        // Random control traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) pause = ~pause;
            if ($urandom_range(0, 79) == 0) loop_en = ~loop_en;
            tick("random");
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        $display("txn random: 3000 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
